// File: rtl/lock_pkg.sv
// Shared definitions for the combination-lock front end and the lock FSM:
// symbol encodings on s[1:0] and the default debounce length.
package lock_pkg;

    localparam logic [1:0] SYM_IDLE = 2'b00;
    localparam logic [1:0] SYM_KEY0 = 2'b01;
    localparam logic [1:0] SYM_KEY1 = 2'b11;

    localparam int DEBOUNCE_DEFAULT = 4;

    // Key index to entry symbol: bit 1 carries the key value, bit 0 the strobe.
    function automatic logic [1:0] sym_for_key(input logic key);
        return {key, 1'b1};
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One button channel: two-flop synchroniser followed by a saturating
// debounce counter that qualifies level changes into a clean level.
module debounce_bit
    import lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // The counter only runs while the synchronised input disagrees with
            // the accepted level; the toggle edge also clears it, so it never wraps.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/keypad_conditioner.sv
// Two-button keypad front end: debounces both keys and turns each clean
// press into a one-cycle entry symbol, rejecting presses that involve both keys.
module keypad_conditioner
    import lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] btn,
    output logic [1:0] s,
    output logic [1:0] btn_state,
    output logic       conflict
);

    logic [1:0] state_p1;
    logic [1:0] rise;
    logic [1:0] s_next;
    logic       conflict_next;

    for (genvar i = 0; i < 2; i++) begin : g_key
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .rst  (rst),
            .raw  (btn[i]),
            .level(btn_state[i])
        );
    end

    // Press detection against the previous debounced level; releases are ignored.
    assign rise = btn_state & ~state_p1;

    always_comb begin
        s_next        = SYM_IDLE;
        conflict_next = 1'b0;
        if (rise == 2'b01 && !btn_state[1]) begin
            s_next = sym_for_key(1'b0);
        end else if (rise == 2'b10 && !btn_state[0]) begin
            s_next = sym_for_key(1'b1);
        end else if (rise != 2'b00) begin
            conflict_next = 1'b1;
        end
    end

    // ---- output stage: registered symbol and conflict pulse ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1 <= 2'b00;
            s        <= SYM_IDLE;
            conflict <= 1'b0;
        end else begin
            state_p1 <= btn_state;
            s        <= s_next;
            conflict <= conflict_next;
        end
    end

endmodule

// File: tb/tb_keypad_conditioner.sv
// Self-checking bench for keypad_conditioner: directed scenarios followed by
// randomized button activity, all compared against a behavioural model.
module tb_keypad_conditioner;
    import lock_pkg::*;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] btn = 2'b00;
    logic [1:0] s;
    logic [1:0] btn_state;
    logic       conflict;

    int total = 0;
    int bad   = 0;

    keypad_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .s        (s),
        .btn_state(btn_state),
        .conflict (conflict)
    );

    always #5 clk = ~clk;

    // Behavioural model: a raw level reaches the debouncer two edges later and
    // is accepted once it has disagreed with the accepted level D edges running.
    bit [1:0] pipe_q[$];
    bit [1:0] acc_m;
    bit [1:0] acc_prev_m;
    int       run_m[2];
    bit [1:0] s_m;
    bit       c_m;

    task automatic model_edge(input bit [1:0] b, input bit r);
        bit [1:0] seen;
        bit [1:0] pressed;
        if (r) begin
            pipe_q = '{2'b00, 2'b00};
            acc_m = 0; acc_prev_m = 0; run_m[0] = 0; run_m[1] = 0;
            s_m = SYM_IDLE; c_m = 0;
            return;
        end
        pressed = acc_m & ~acc_prev_m;
        s_m = SYM_IDLE; c_m = 0;
        if (pressed == 2'b01 && acc_m[1] == 0)      s_m = SYM_KEY0;
        else if (pressed == 2'b10 && acc_m[0] == 0) s_m = SYM_KEY1;
        else if (pressed != 0)                      c_m = 1;
        acc_prev_m = acc_m;
        seen = pipe_q[0];
        for (int i = 0; i < 2; i++) begin
            run_m[i] = (seen[i] != acc_m[i]) ? run_m[i] + 1 : 0;
            if (run_m[i] == D) begin
                acc_m[i] = ~acc_m[i];
                run_m[i] = 0;
            end
        end
        void'(pipe_q.pop_front());
        pipe_q.push_back(b);
    endtask

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One clock: edge, model update with the values present at the edge, then compare.
    task automatic tick();
        bit [1:0] b_now;
        bit       r_now;
        b_now = btn; r_now = rst;
        @(posedge clk);
        model_edge(b_now, r_now);
        #1;
        chk("s", s, s_m);
        chk("btn_state", btn_state, acc_m);
        chk("conflict", {1'b0, conflict}, {1'b0, c_m});
        chk("s_not_10", {1'b0, s == 2'b10}, 2'b00);
    endtask

    int n_k0, n_k1, n_cf, first_k0, first_k1, first_cf, first_st0;

    task automatic run(input int n);
        n_k0 = 0; n_k1 = 0; n_cf = 0; first_k0 = -1; first_k1 = -1; first_cf = -1; first_st0 = -1;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (s == SYM_KEY0) begin n_k0++; if (first_k0 < 0) first_k0 = k; end
            if (s == SYM_KEY1) begin n_k1++; if (first_k1 < 0) first_k1 = k; end
            if (conflict)      begin n_cf++; if (first_cf < 0) first_cf = k; end
            if (btn_state[0] && first_st0 < 0) first_st0 = k;
        end
    endtask

    initial begin
        pipe_q = '{2'b00, 2'b00};
        acc_m = 0; acc_prev_m = 0; run_m[0] = 0; run_m[1] = 0; s_m = 0; c_m = 0;

        // Reset held with both buttons pressed
        rst = 1'b1; btn = 2'b11;
        run(3);
        chk("rst_state", btn_state, 2'b00);
        rst = 1'b0;
        run(14);
        chk_int("rst_release_conflicts", n_cf, 1);
        chk_int("rst_release_strobes", n_k0 + n_k1, 0);
        btn = 2'b00; run(14);

        // Clean press on key 0, then a long hold
        btn = 2'b01;
        run(8);
        chk_int("press0_state_edge", first_st0, 6);
        chk_int("press0_strobe_edge", first_k0, 7);
        chk_int("press0_strobes", n_k0, 1);
        run(50);
        chk_int("hold0_no_repeat", n_k0 + n_k1 + n_cf, 0);
        btn = 2'b00; run(14);
        chk_int("release0_no_event", n_k0 + n_k1 + n_cf, 0);

        // Bouncing key 1: never stable for D cycles
        btn = 2'b10; run(3);
        btn = 2'b00; run(2);
        btn = 2'b10; run(2);
        btn = 2'b00; run(12);
        chk_int("bounce_no_strobe", n_k1, 0);
        chk("bounce_state", btn_state, 2'b00);
        btn = 2'b10; run(10);
        chk_int("hold1_strobe_edge", first_k1, 7);
        chk_int("hold1_strobes", n_k1, 1);
        btn = 2'b00; run(14);

        // Simultaneous press
        btn = 2'b11; run(12);
        chk_int("simul_conflict_edge", first_cf, 7);
        chk_int("simul_conflicts", n_cf, 1);
        chk_int("simul_strobes", n_k0 + n_k1, 0);
        btn = 2'b00; run(14);

        // Overlapping press: key 0 held, then key 1
        btn = 2'b01; run(10);
        chk_int("overlap_first_strobe", n_k0, 1);
        btn = 2'b11; run(12);
        chk_int("overlap_conflicts", n_cf, 1);
        chk_int("overlap_no_key1", n_k1, 0);
        btn = 2'b01; run(12);
        btn = 2'b00; run(12);
        chk_int("overlap_release_quiet", n_k0 + n_k1 + n_cf, 0);

        // Reset in the middle of debouncing a held key 0
        btn = 2'b01; run(3);
        chk_int("middeb_no_early", n_k0, 0);
        rst = 1'b1; run(1);
        rst = 1'b0; run(20);
        chk_int("middeb_strobe_edge", first_k0, 7);
        chk_int("middeb_strobes", n_k0, 1);
        btn = 2'b00; run(14);

        // Randomized activity with occasional resets
        for (int seg = 0; seg < 250; seg++) begin
            btn = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 39) == 0);
            if (rst) run(1);
            rst = 1'b0;
            run($urandom_range(1, 12));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
